trisc_mem_arbiter: RTL and testbench
====================================

TRISC_MEM_ARBITER -- requirements
Module: trisc_mem_arbiter

Interface
REQ-001 Parameter AW, default 4, memory address width in bits.
REQ-002 Parameter DW, default 8, memory data width in bits.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: port Clock, input, 1, rising-edge clock.
REQ-004 Port Resetn, input, 1, asynchronous active-low reset.
REQ-005 Ports req0/req1, input, 1 each, access request; 0 = CPU controller, 1 = I/O loader.
REQ-006 Ports we0/we1, input, 1 each, write enable qualifying the request (1 = write, 0 = read).
REQ-007 Ports addr0/addr1, input, AW each, request address.
REQ-008 Ports wdata0/wdata1, input, DW each, write data.
REQ-009 Ports ack0/ack1, output, 1 each, one-cycle completion pulse per requester.
REQ-010 Port rdata, output, DW, read data; valid in the ack cycle.
REQ-011 Port mem_en, output, 1, memory access strobe.
REQ-012 Port mem_we, output, 1, memory write strobe.
REQ-013 Port mem_addr, output, AW, memory address.
REQ-014 Port mem_wdata, output, DW, memory write data.
REQ-015 Port mem_rdata, input, DW, memory read data; valid one cycle after mem_en.
REQ-016 Port busy, output, 1, high whenever the state is not IDLE.
REQ-017 Port gnt_id, output, 1, index of the requester currently or last served.

Function
REQ-018 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-019 IDLE: if req0 or req1 is sampled high, select the winner, latch its we/addr/wdata, set gnt_id, and go to ACCESS; otherwise stay in IDLE.
REQ-020 Arbitration SHALL be round-robin: if both requests are high, grant the requester other than last_gnt; if one is high, grant it.
REQ-021 ACCESS: mem_en=1, with mem_we/mem_addr/mem_wdata driven from the latched values; go to RESP.
REQ-022 RESP: register mem_rdata into rdata, pulse ack[gnt_id] for exactly one cycle, update last_gnt=gnt_id, and go to IDLE.
REQ-023 Latency: a request sampled at edge k SHALL produce ACCESS in cycle k+1 and ack in cycle k+2; minimum spacing between acks is 3 cycles.
REQ-024 Outside ACCESS, mem_en and mem_we SHALL be 0; mem_addr and mem_wdata hold their last values.
REQ-025 On writes, rdata SHALL hold its previous value.
REQ-026 Requests and qualifiers SHALL be ignored outside IDLE; input changes during ACCESS or RESP do not alter the transaction.
REQ-027 A requester dropping req after grant SHALL still receive its ack; the transaction is not cancelled.
REQ-028 A requester holding req through its ack cycle SHALL be treated as a new request in the following IDLE cycle.
REQ-029 ack0 and ack1 SHALL never be high in the same cycle.
REQ-030 Fairness: with both requesters continuously requesting, grants SHALL strictly alternate, so each requester waits at most one foreign transaction.
REQ-031 All outputs SHALL be registered or decoded from state only, with no combinational path from req to mem_*.

Reset
REQ-032 On Resetn low (asynchronous): state=IDLE, last_gnt=1 (CPU wins the first tie), gnt_id=0, ack0=ack1=0, mem_en=mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, busy=0.
REQ-033 Reset asserted mid-transaction SHALL abort it with no ack and no write strobe after the reset edge.
REQ-034 Deassertion is synchronised externally; the first grant can occur on the first rising edge after release.

Structure
REQ-035 A shared package SHALL hold the state encoding (IDLE=2'b00, ACCESS=2'b01, RESP=2'b10), the requester index constants (CPU=0, IO=1) and the AW/DW defaults, shared with the TRISC controller.
REQ-036 One sub-module is natural: trisc_rr_pick, a 2-way round-robin selector with inputs req[1:0] and last_gnt and outputs gnt_valid and gnt_idx.
REQ-037 Unused state encoding 2'b11 SHALL recover to IDLE.

Verification
REQ-038 Single read: req0=1, we0=0, addr0=4'h5, memory[5]=8'hA7 -> mem_en high in cycle 1, ack0 in cycle 2, rdata=8'hA7.
REQ-039 Single write: req1=1, we1=1, addr1=4'hC, wdata1=8'h3C -> mem_en=mem_we=1 with mem_addr=C and mem_wdata=3C for one cycle; ack1 one cycle later; rdata unchanged.
REQ-040 Tie after reset: req0=req1=1 held for 12 cycles -> ack sequence 0,1,0,1 at cycles 2,5,8,11.
REQ-041 Mid-flight change: grant req0 at addr 2, then change addr0 to 9 and drop req0 during ACCESS -> mem_addr=2 and ack0 still issued.
REQ-042 Reset mid-ACCESS: assert Resetn=0 in an ACCESS cycle -> mem_en, mem_we and busy go 0 immediately, and no ack is issued.
REQ-043 Continuous checks on every cycle: ack0 and ack1 never both high, and mem_en high only in ACCESS.

Source files
------------

// File: rtl/trisc_mem_arbiter_pkg.sv
// Shared definitions for the TRISC memory arbiter and the TRISC controller:
// FSM encoding, requester indices and default bus widths.
package trisc_mem_arbiter_pkg;

  localparam int unsigned AW_DEFAULT = 4;
  localparam int unsigned DW_DEFAULT = 8;

  localparam logic CPU = 1'b0;
  localparam logic IO  = 1'b1;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StAccess = 2'b01,
    StResp   = 2'b10
  } arb_state_e;

  // Index of the requester that is not idx.
  function automatic logic other_req(input logic idx);
    return ~idx;
  endfunction

endpackage

// File: rtl/trisc_rr_pick.sv
// Two-way round-robin selector: on a tie, the requester not served last wins.
module trisc_rr_pick
  import trisc_mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  always_comb begin
    gnt_valid = |req;
    gnt_idx   = CPU;
    unique case (req)
      2'b01:   gnt_idx = CPU;
      2'b10:   gnt_idx = IO;
      2'b11:   gnt_idx = other_req(last_gnt);
      default: gnt_idx = CPU;
    endcase
  end

endmodule

// File: rtl/trisc_mem_arbiter.sv
// Arbitrates a CPU controller and an I/O loader onto one single-port memory.
// Each transaction walks IDLE -> ACCESS -> RESP; the ack is issued in RESP.
module trisc_mem_arbiter
  import trisc_mem_arbiter_pkg::*;
#(
  parameter int unsigned AW = AW_DEFAULT,
  parameter int unsigned DW = DW_DEFAULT
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          gnt_id
);

  arb_state_e    r_state;
  arb_state_e    w_state_nxt;
  logic          r_last_gnt;
  logic          r_gnt_id;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;

  logic          w_gnt_valid;
  logic          w_gnt_idx;
  logic          w_grant;
  logic          w_sel_we;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;
  logic          w_in_access;
  logic          w_in_resp;

  trisc_rr_pick u_rr_pick (
    .req       ({req1, req0}),
    .last_gnt  (r_last_gnt),
    .gnt_valid (w_gnt_valid),
    .gnt_idx   (w_gnt_idx)
  );

  assign w_sel_we    = (w_gnt_idx == IO) ? we1    : we0;
  assign w_sel_addr  = (w_gnt_idx == IO) ? addr1  : addr0;
  assign w_sel_wdata = (w_gnt_idx == IO) ? wdata1 : wdata0;

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_gnt_valid) begin
          w_grant     = 1'b1;
          w_state_nxt = StAccess;
        end
      end
      StAccess: w_state_nxt = StResp;
      StResp:   w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state    <= StIdle;
      r_last_gnt <= IO;
      r_gnt_id   <= CPU;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_gnt_id <= w_gnt_idx;
        r_we     <= w_sel_we;
        r_addr   <= w_sel_addr;
        r_wdata  <= w_sel_wdata;
      end
      if (w_in_resp) begin
        r_last_gnt <= r_gnt_id;
        if (!r_we) r_rdata <= mem_rdata;
      end
    end
  end

  assign w_in_access = (r_state == StAccess);
  assign w_in_resp   = (r_state == StResp);

  assign mem_en    = w_in_access;
  assign mem_we    = w_in_access & r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  assign busy   = (r_state != StIdle);
  assign gnt_id = r_gnt_id;
  assign ack0   = w_in_resp & (r_gnt_id == CPU);
  assign ack1   = w_in_resp & (r_gnt_id == IO);

  // Memory data arrives in the ack cycle, so a read forwards it there; the
  // register keeps it stable afterwards and across writes.
  assign rdata = (w_in_resp && !r_we) ? mem_rdata : r_rdata;

endmodule

// File: tb/tb_trisc_mem_arbiter.sv
// Self-checking bench: vector table, directed corner sequences and a
// randomized run against a transaction-level reference model.
module tb_trisc_mem_arbiter;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;

  logic          Clock  = 1'b0;
  logic          Resetn = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          ack0, ack1, mem_en, mem_we, busy, gnt_id;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  logic          preload = 1'b0;
  logic [DW-1:0] mem [16];

  int n_total = 0;
  int n_pass  = 0;

  always #5 Clock = ~Clock;

  trisc_mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .req0      (req0),
    .req1      (req1),
    .we0       (we0),
    .we1       (we1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .ack0      (ack0),
    .ack1      (ack1),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .gnt_id    (gnt_id)
  );

  // Synchronous-read memory: data appears the cycle after mem_en.
  always @(posedge Clock) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'hA2 + 8'(i);
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge Clock) begin
    if (Resetn === 1'b1) begin
      chk("ack_exclusive", 32'(ack0 & ack1), 32'd0);
      chk("mem_en_only_in_access", 32'(mem_en & (ack0 | ack1 | ~busy)), 32'd0);
    end
  end

  task automatic reset_checks(input string tag);
    chk({tag, "_ack0"},      32'(ack0),      32'd0);
    chk({tag, "_ack1"},      32'(ack1),      32'd0);
    chk({tag, "_mem_en"},    32'(mem_en),    32'd0);
    chk({tag, "_mem_we"},    32'(mem_we),    32'd0);
    chk({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_rdata"},     32'(rdata),     32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_gnt_id"},    32'(gnt_id),    32'd0);
  endtask

  task automatic do_reset();
    Resetn = 1'b0; preload = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    @(negedge Clock);
    #1 reset_checks("reset");
    @(negedge Clock);
    preload = 1'b0; Resetn = 1'b1;
  endtask

  typedef struct {
    logic       r0, r1, w0, w1;
    logic [3:0] a0, a1;
    logic [7:0] d0, d1;
    logic       id, we;
    logic [3:0] addr;
    logic [7:0] wd, rdata;
  } vec_t;

  vec_t tbl [7];

  // Reference model state for the random run.
  logic [7:0] mmem [16];

  initial begin
    tbl[0] = '{r0:1'b1, r1:1'b0, w0:1'b0, w1:1'b0, a0:4'h5, a1:4'h0, d0:8'h11, d1:8'h22,
               id:1'b0, we:1'b0, addr:4'h5, wd:8'h11, rdata:8'hA7};
    tbl[1] = '{r0:1'b0, r1:1'b1, w0:1'b0, w1:1'b1, a0:4'h0, a1:4'hC, d0:8'h00, d1:8'h3C,
               id:1'b1, we:1'b1, addr:4'hC, wd:8'h3C, rdata:8'hA7};
    tbl[2] = '{r0:1'b1, r1:1'b1, w0:1'b0, w1:1'b0, a0:4'hC, a1:4'h3, d0:8'h44, d1:8'h66,
               id:1'b0, we:1'b0, addr:4'hC, wd:8'h44, rdata:8'h3C};
    tbl[3] = '{r0:1'b1, r1:1'b1, w0:1'b1, w1:1'b0, a0:4'h1, a1:4'h0, d0:8'h55, d1:8'h77,
               id:1'b1, we:1'b0, addr:4'h0, wd:8'h77, rdata:8'hA2};
    tbl[4] = '{r0:1'b0, r1:1'b1, w0:1'b0, w1:1'b1, a0:4'h0, a1:4'h7, d0:8'h00, d1:8'h99,
               id:1'b1, we:1'b1, addr:4'h7, wd:8'h99, rdata:8'hA2};
    tbl[5] = '{r0:1'b1, r1:1'b1, w0:1'b0, w1:1'b1, a0:4'h7, a1:4'h0, d0:8'h00, d1:8'hEE,
               id:1'b0, we:1'b0, addr:4'h7, wd:8'h00, rdata:8'h99};
    tbl[6] = '{r0:1'b1, r1:1'b0, w0:1'b0, w1:1'b0, a0:4'hF, a1:4'h0, d0:8'h00, d1:8'h00,
               id:1'b0, we:1'b0, addr:4'hF, wd:8'h00, rdata:8'hB1};

    // Vector table: one transaction per entry, inputs scrambled during ACCESS.
    do_reset();
    for (int k = 0; k < 7; k++) begin
      vec_t v;
      v = tbl[k];
      req0 = v.r0; req1 = v.r1; we0 = v.w0; we1 = v.w1;
      addr0 = v.a0; addr1 = v.a1; wdata0 = v.d0; wdata1 = v.d1;
      @(negedge Clock);
      chk("tbl_acc_mem_en",    32'(mem_en),    32'd1);
      chk("tbl_acc_mem_we",    32'(mem_we),    32'(v.we));
      chk("tbl_acc_mem_addr",  32'(mem_addr),  32'(v.addr));
      chk("tbl_acc_mem_wdata", 32'(mem_wdata), 32'(v.wd));
      chk("tbl_acc_gnt_id",    32'(gnt_id),    32'(v.id));
      chk("tbl_acc_busy",      32'(busy),      32'd1);
      chk("tbl_acc_acks",      32'({ack1, ack0}), 32'd0);
      req0 = 1'b0; req1 = 1'b0; we0 = ~we0; we1 = ~we1;
      addr0 = ~addr0; addr1 = ~addr1; wdata0 = ~wdata0; wdata1 = ~wdata1;
      @(negedge Clock);
      chk("tbl_resp_ack0",     32'(ack0),      32'(v.id == 1'b0));
      chk("tbl_resp_ack1",     32'(ack1),      32'(v.id == 1'b1));
      chk("tbl_resp_rdata",    32'(rdata),     32'(v.rdata));
      chk("tbl_resp_mem_en",   32'({mem_en, mem_we}), 32'd0);
      chk("tbl_resp_mem_addr", 32'(mem_addr),  32'(v.addr));
      chk("tbl_resp_busy",     32'(busy),      32'd1);
      @(negedge Clock);
      chk("tbl_idle_busy",     32'(busy),      32'd0);
      chk("tbl_idle_acks",     32'({ack1, ack0}), 32'd0);
      chk("tbl_idle_rdata",    32'(rdata),     32'(v.rdata));
      chk("tbl_idle_mem_wdata", 32'(mem_wdata), 32'(v.wd));
    end

    // Tie after reset, both held: acks 0,1,0,1 at cycles 2,5,8,11.
    do_reset();
    req0 = 1'b1; req1 = 1'b1; addr0 = 4'h1; addr1 = 4'h2;
    for (int t = 1; t <= 12; t++) begin
      @(negedge Clock);
      chk($sformatf("tie_ack0_c%0d", t), 32'(ack0), 32'(t == 2 || t == 8));
      chk($sformatf("tie_ack1_c%0d", t), 32'(ack1), 32'(t == 5 || t == 11));
      chk($sformatf("tie_mem_en_c%0d", t), 32'(mem_en), 32'(t % 3 == 1));
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge Clock);

    // Mid-flight change: address change and dropped request are ignored.
    req0 = 1'b1; we0 = 1'b0; addr0 = 4'h2;
    @(negedge Clock);
    chk("mid_acc_mem_addr", 32'(mem_addr), 32'h2);
    chk("mid_acc_mem_en",   32'(mem_en),   32'd1);
    addr0 = 4'h9; req0 = 1'b0;
    @(negedge Clock);
    chk("mid_resp_ack0",     32'(ack0),     32'd1);
    chk("mid_resp_mem_addr", 32'(mem_addr), 32'h2);
    chk("mid_resp_rdata",    32'(rdata),    32'hA4);
    @(negedge Clock);
    chk("mid_idle_ack0",     32'(ack0),     32'd0);
    chk("mid_idle_mem_addr", 32'(mem_addr), 32'h2);

    // Reset during ACCESS of a write: strobes drop at once, no ack, no write.
    req1 = 1'b1; we1 = 1'b1; addr1 = 4'h6; wdata1 = 8'h5A;
    @(negedge Clock);
    chk("rst_pre_mem_we", 32'(mem_we), 32'd1);
    Resetn = 1'b0;
    #1 reset_checks("rst_mid");
    req1 = 1'b0; we1 = 1'b0;
    @(negedge Clock);
    Resetn = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(negedge Clock);
      chk("rst_after_acks", 32'({ack1, ack0}), 32'd0);
      chk("rst_after_busy", 32'(busy), 32'd0);
    end
    req0 = 1'b1; we0 = 1'b0; addr0 = 4'h6;
    @(negedge Clock);
    req0 = 1'b0;
    @(negedge Clock);
    chk("rst_no_write_ack0",  32'(ack0),  32'd1);
    chk("rst_no_write_rdata", 32'(rdata), 32'hA8);
    @(negedge Clock);

    // Random traffic against a transaction-level model.
    do_reset();
    begin
      int         free_at;
      bit         t_valid;
      int         t_acc;
      logic       t_id, t_we, m_last, m_gnt;
      logic [3:0] t_addr, m_addr;
      logic [7:0] t_wd, m_wd, m_rdata;
      logic       in_acc, in_resp;
      free_at = 0; t_valid = 1'b0; t_acc = 0;
      t_id = 1'b0; t_we = 1'b0; t_addr = '0; t_wd = '0;
      m_last = 1'b1; m_gnt = 1'b0; m_addr = '0; m_wd = '0; m_rdata = '0;
      for (int a = 0; a < 16; a++) mmem[a] = 8'hA2 + 8'(a);
      for (int i = 0; i < 600; i++) begin
        in_acc  = t_valid && (i == t_acc);
        in_resp = t_valid && (i == t_acc + 1);
        if (in_acc) begin
          m_gnt = t_id; m_addr = t_addr; m_wd = t_wd;
        end
        if (in_resp) begin
          if (t_we) mmem[t_addr] = t_wd;
          else      m_rdata = mmem[t_addr];
          m_last = t_id;
        end
        chk("rnd_mem_en",    32'(mem_en),    32'(in_acc));
        chk("rnd_mem_we",    32'(mem_we),    32'(in_acc && t_we));
        chk("rnd_mem_addr",  32'(mem_addr),  32'(m_addr));
        chk("rnd_mem_wdata", 32'(mem_wdata), 32'(m_wd));
        chk("rnd_gnt_id",    32'(gnt_id),    32'(m_gnt));
        chk("rnd_busy",      32'(busy),      32'(in_acc || in_resp));
        chk("rnd_ack0",      32'(ack0),      32'(in_resp && t_id == 1'b0));
        chk("rnd_ack1",      32'(ack1),      32'(in_resp && t_id == 1'b1));
        chk("rnd_rdata",     32'(rdata),     32'(m_rdata));
        req0 = ($urandom_range(0, 2) != 0);
        req1 = ($urandom_range(0, 2) != 0);
        we0  = 1'($urandom_range(0, 1));
        we1  = 1'($urandom_range(0, 1));
        addr0  = 4'($urandom_range(0, 15));
        addr1  = 4'($urandom_range(0, 15));
        wdata0 = 8'($urandom_range(0, 255));
        wdata1 = 8'($urandom_range(0, 255));
        if (i >= free_at && (req0 || req1)) begin
          t_id    = (req0 && req1) ? ~m_last : req1;
          t_we    = t_id ? we1 : we0;
          t_addr  = t_id ? addr1 : addr0;
          t_wd    = t_id ? wdata1 : wdata0;
          t_acc   = i + 1;
          free_at = i + 3;
          t_valid = 1'b1;
        end
        @(negedge Clock);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
